// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with a registered output stage.
// The source channel is chosen either by an external select or by round-robin arbitration.
module stream_mux_rr #(
    parameter int  N    = 4,
    parameter int  W    = 8,
    parameter int  MODE = 1,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [CW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    input  logic           out_ready
);

    logic [CW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [CW-1:0] grant_idx;
    logic [CW:0]   rr_idx;
    logic          load;

    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N{load}} & ~{N{rst}};

    // Round-robin scans offsets from high to low so the nearest requester at or above ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        rr_idx    = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (sel == CW'(i)) begin
                    grant[i]  = in_valid[i];
                    grant_idx = CW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                rr_idx = {1'b0, ptr} + (CW+1)'(i);
                if (rr_idx >= (CW+1)'(N)) begin
                    rr_idx = rr_idx - (CW+1)'(N);
                end
                if (in_valid[rr_idx[CW-1:0]]) begin
                    grant                 = '0;
                    grant[rr_idx[CW-1:0]] = 1'b1;
                    grant_idx             = rr_idx[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (|grant) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*W +: W];
                out_chan  <= grant_idx;
                if (MODE != 0) begin
                    ptr <= (grant_idx == CW'(N - 1)) ? '0 : grant_idx + CW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
